// File: rtl/q_pkg.sv
// Shared widths and types for the Q-value maximum selector.
package q_pkg;

   localparam int unsigned Q_W       = 16;
   localparam int unsigned N_ACTIONS = 9;
   localparam int unsigned IDX_W     = 4;

   typedef logic [Q_W-1:0] q_val_t;

endpackage

// File: rtl/q_cmp2.sv
// Comparator tree node: forwards the larger of two (value, index) pairs.
// Pair a must carry the lower index; b wins only when strictly greater.
module q_cmp2
   import q_pkg::*;
#(
   parameter int unsigned W          = Q_W,
   parameter bit          SIGNED_CMP = 1'b1
) (
   input  logic [W-1:0]     a_val,
   input  logic [IDX_W-1:0] a_idx,
   input  logic [W-1:0]     b_val,
   input  logic [IDX_W-1:0] b_idx,
   output logic [W-1:0]     max_val,
   output logic [IDX_W-1:0] max_idx
);

   logic b_gt;

   // Relational compare only, so no subtraction overflow at the signed extremes.
   always_comb begin
      b_gt = 1'b0;
      if (SIGNED_CMP) begin
         b_gt = $signed(b_val) > $signed(a_val);
      end else begin
         b_gt = b_val > a_val;
      end
   end

   always_comb begin
      max_val = a_val;
      max_idx = a_idx;
      if (b_gt) begin
         max_val = b_val;
         max_idx = b_idx;
      end
   end

endmodule

// File: rtl/q_max_sel.sv
// Registered maximum of nine Q-values with the lowest winning cell index.
module q_max_sel
   import q_pkg::*;
#(
   parameter int unsigned W          = Q_W,
   parameter bit          SIGNED_CMP = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [W-1:0]     input_1,
   input  logic [W-1:0]     input_2,
   input  logic [W-1:0]     input_3,
   input  logic [W-1:0]     input_4,
   input  logic [W-1:0]     input_5,
   input  logic [W-1:0]     input_6,
   input  logic [W-1:0]     input_7,
   input  logic [W-1:0]     input_8,
   input  logic [W-1:0]     input_9,
   output logic [W-1:0]     keluaran,
   output logic [IDX_W-1:0] max_idx,
   output logic             out_valid
);

   logic [W-1:0]     in_vals [N_ACTIONS];
   logic [W-1:0]     l1_val  [4];
   logic [IDX_W-1:0] l1_idx  [4];
   logic [W-1:0]     l2_val  [2];
   logic [IDX_W-1:0] l2_idx  [2];
   logic [W-1:0]     l3_val;
   logic [IDX_W-1:0] l3_idx;
   logic [W-1:0]     best_val;
   logic [IDX_W-1:0] best_idx;

   assign in_vals[0] = input_1;
   assign in_vals[1] = input_2;
   assign in_vals[2] = input_3;
   assign in_vals[3] = input_4;
   assign in_vals[4] = input_5;
   assign in_vals[5] = input_6;
   assign in_vals[6] = input_7;
   assign in_vals[7] = input_8;
   assign in_vals[8] = input_9;

   // Lower-index operand always goes on port a so ties resolve toward cell 1.
   for (genvar g = 0; g < 4; g++) begin : g_l1
      q_cmp2 #(
         .W          (W),
         .SIGNED_CMP (SIGNED_CMP)
      ) u_cmp (
         .a_val   (in_vals[2*g]),
         .a_idx   (IDX_W'(2*g)),
         .b_val   (in_vals[2*g+1]),
         .b_idx   (IDX_W'(2*g+1)),
         .max_val (l1_val[g]),
         .max_idx (l1_idx[g])
      );
   end

   for (genvar g = 0; g < 2; g++) begin : g_l2
      q_cmp2 #(
         .W          (W),
         .SIGNED_CMP (SIGNED_CMP)
      ) u_cmp (
         .a_val   (l1_val[2*g]),
         .a_idx   (l1_idx[2*g]),
         .b_val   (l1_val[2*g+1]),
         .b_idx   (l1_idx[2*g+1]),
         .max_val (l2_val[g]),
         .max_idx (l2_idx[g])
      );
   end

   q_cmp2 #(
      .W          (W),
      .SIGNED_CMP (SIGNED_CMP)
   ) u_l3 (
      .a_val   (l2_val[0]),
      .a_idx   (l2_idx[0]),
      .b_val   (l2_val[1]),
      .b_idx   (l2_idx[1]),
      .max_val (l3_val),
      .max_idx (l3_idx)
   );

   q_cmp2 #(
      .W          (W),
      .SIGNED_CMP (SIGNED_CMP)
   ) u_l4 (
      .a_val   (l3_val),
      .a_idx   (l3_idx),
      .b_val   (in_vals[8]),
      .b_idx   (IDX_W'(8)),
      .max_val (best_val),
      .max_idx (best_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         keluaran  <= '0;
         max_idx   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            keluaran <= best_val;
            max_idx  <= best_idx;
         end
      end
   end

endmodule

// File: tb/tb_q_max_sel.sv
// Directed and random checks of q_max_sel in signed and unsigned builds.
module tb_q_max_sel;
   import q_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   q_val_t      vin [9];
   logic [15:0] ks, ku;
   logic [3:0]  is_, iu;
   logic        vs, vu;

   logic [15:0] exp_ks, exp_ku;
   logic [3:0]  exp_is, exp_iu;
   logic        exp_v;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   q_max_sel #(.W(16), .SIGNED_CMP(1'b1)) dut_s (
      .clk (clk), .rst (rst), .in_valid (in_valid),
      .input_1 (vin[0]), .input_2 (vin[1]), .input_3 (vin[2]),
      .input_4 (vin[3]), .input_5 (vin[4]), .input_6 (vin[5]),
      .input_7 (vin[6]), .input_8 (vin[7]), .input_9 (vin[8]),
      .keluaran (ks), .max_idx (is_), .out_valid (vs)
   );

   q_max_sel #(.W(16), .SIGNED_CMP(1'b0)) dut_u (
      .clk (clk), .rst (rst), .in_valid (in_valid),
      .input_1 (vin[0]), .input_2 (vin[1]), .input_3 (vin[2]),
      .input_4 (vin[3]), .input_5 (vin[4]), .input_6 (vin[5]),
      .input_7 (vin[6]), .input_8 (vin[7]), .input_9 (vin[8]),
      .keluaran (ku), .max_idx (iu), .out_valid (vu)
   );

   // Reference: numeric maximum first, then the first cell holding it.
   function automatic void ref_max(input bit sgn, output logic [15:0] mv, output logic [3:0] mi);
      int nums [9];
      int best;
      for (int i = 0; i < 9; i++) nums[i] = sgn ? int'($signed(vin[i])) : int'({16'h0, vin[i]});
      best = nums[0];
      for (int i = 1; i < 9; i++) if (nums[i] > best) best = nums[i];
      mi = 4'd0;
      for (int i = 8; i >= 0; i--) if (nums[i] == best) mi = 4'(i);
      mv = vin[mi];
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".s_val"}, ks, exp_ks);
      chk({tag, ".s_idx"}, {12'h0, is_}, {12'h0, exp_is});
      chk({tag, ".s_vld"}, {15'h0, vs}, {15'h0, exp_v});
      chk({tag, ".u_val"}, ku, exp_ku);
      chk({tag, ".u_idx"}, {12'h0, iu}, {12'h0, exp_iu});
      chk({tag, ".u_vld"}, {15'h0, vu}, {15'h0, exp_v});
   endtask

   // Inputs in vin are set by the caller; valid is applied at the falling edge.
   task automatic step(input bit valid, input string tag);
      @(negedge clk);
      in_valid = valid;
      if (valid) begin
         ref_max(1'b1, exp_ks, exp_is);
         ref_max(1'b0, exp_ku, exp_iu);
      end
      exp_v = valid;
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   task automatic clear_exp();
      exp_ks = '0; exp_ku = '0; exp_is = '0; exp_iu = '0; exp_v = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      foreach (vin[i]) vin[i] = '0;
      clear_exp();
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset_held");

      @(negedge clk);
      rst = 1'b0;
      step(1'b0, "post_reset_idle");

      for (int i = 0; i < 9; i++) vin[i] = q_val_t'(10 * (i + 1));
      step(1'b1, "ascending");
      chk("ascending.fixed_idx", {12'h0, is_}, 16'd8);
      for (int i = 0; i < 9; i++) vin[i] = q_val_t'(10 * (9 - i));
      step(1'b1, "descending");
      chk("descending.fixed_val", ks, 16'd90);

      foreach (vin[i]) vin[i] = 16'h0100;
      vin[2] = 16'h0500;
      vin[6] = 16'h0500;
      step(1'b1, "tie");
      chk("tie.fixed_idx", {12'h0, is_}, 16'd2);

      foreach (vin[i]) vin[i] = 16'h1234;
      step(1'b1, "all_equal");

      foreach (vin[i]) vin[i] = 16'hFF00;
      vin[4] = 16'hFFFF;
      step(1'b1, "neg");
      chk("neg.fixed_idx", {12'h0, is_}, 16'd4);
      vin[8] = 16'h0000;
      step(1'b1, "neg_zero9");
      chk("neg_zero9.fixed_idx", {12'h0, is_}, 16'd8);

      foreach (vin[i]) vin[i] = 16'h7FFF;
      vin[0] = 16'h8000;
      step(1'b1, "extremes");
      chk("extremes.fixed_u_val", ku, 16'h8000);
      chk("extremes.fixed_s_idx", {12'h0, is_}, 16'd1);

      // Three back-to-back sets, then hold.
      for (int k = 0; k < 3; k++) begin
         foreach (vin[i]) vin[i] = q_val_t'(i + k);
         vin[(k * 3) % 9] = q_val_t'(16'h0200 + k);
         step(1'b1, "stream");
      end
      foreach (vin[i]) vin[i] = 16'h7777;
      step(1'b0, "stream_hold0");
      step(1'b0, "stream_hold1");

      // Mid-cycle reset clears outputs at once and drops the pending valid.
      foreach (vin[i]) vin[i] = q_val_t'(16'h0040 + i);
      step(1'b1, "pre_reset");
      @(negedge clk);
      in_valid = 1'b1;
      #2;
      rst = 1'b1;
      clear_exp();
      #1;
      chk_all("async_reset");
      @(posedge clk);
      #1;
      chk_all("reset_drop_valid");
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      step(1'b0, "reset_release");

      for (int n = 0; n < 1000; n++) begin
         foreach (vin[i]) begin
            if ($urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 4))
                  0: vin[i] = 16'h0000;
                  1: vin[i] = 16'h8000;
                  2: vin[i] = 16'h7FFF;
                  3: vin[i] = 16'hFFFF;
                  default: vin[i] = 16'h0100;
               endcase
            end else begin
               vin[i] = q_val_t'($urandom);
            end
         end
         step($urandom_range(0, 7) != 0, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
